xlock_key_loader: RTL and testbench

Parametrised key-management and XOR key-gate stage for XOR-locked netlists. It accepts a secret key over a narrow beat-serial handshake into a shadow register and validates the framing. On a valid final beat it commits the key atomically to the active register. Once armed, it XORs a registered data path with the active key; while unarmed it blocks all data.

---
 rtl/xlock_key_loader.sv | 107 ++++++++++
 tb/tb_xlock_key_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/xlock_key_loader.sv
// Beat-serial key loader with atomic commit and XOR key-gate on a 1-cycle registered data path.
// Optional even-parity check on key beats when XLOCK_KEY_PARITY_EN is defined.
module xlock_key_loader #(
  parameter int KEY_W   = 64,
  parameter int SHIFT_W = 8,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [SHIFT_W-1:0] key_data,
  input  logic               key_last,
`ifdef XLOCK_KEY_PARITY_EN
  input  logic               key_par,
`endif
  input  logic               key_clear,
  input  logic               din_valid,
  input  logic [DATA_W-1:0]  din,
  output logic               dout_valid,
  output logic [DATA_W-1:0]  dout,
  output logic               key_armed,
  output logic               key_err
);

  localparam int BEATS = KEY_W / SHIFT_W;
  localparam int BW    = ($clog2(BEATS) + 1 < 4) ? 4 : $clog2(BEATS) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {EMPTY, LOADING, ARMED, ERR} state_t;

  state_t            state, nstate;
  logic [KEY_W-1:0]  shadow, active_key, merged;
  logic [BW-1:0]     bcnt;
  logic [DATA_W-1:0] mask;
  logic              acc, at_last, perr, ferr, bad, commit;

  always_comb begin
    acc     = key_valid && key_ready;
    at_last = (bcnt == LAST_BEAT);
`ifdef XLOCK_KEY_PARITY_EN
    perr    = acc && ((^key_data) != key_par);
`else
    perr    = 1'b0;
`endif
    ferr    = acc && (key_last != at_last);
    bad     = perr || ferr;
    commit  = acc && at_last && key_last && !perr;
    merged  = shadow;
    merged[int'(bcnt)*SHIFT_W +: SHIFT_W] = key_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= nstate;
  end

  // key_clear outranks any beat in the same cycle; errors outrank commit
  always_comb begin
    nstate = state;
    if (key_clear)                   nstate = EMPTY;
    else if (bad)                    nstate = ERR;
    else if (commit)                 nstate = ARMED;
    else if (acc && state == EMPTY)  nstate = LOADING;
  end

  always_comb begin
    key_ready = (state != ERR);
    key_armed = (state == ARMED);
    key_err   = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || key_clear || bad) begin
      shadow     <= '0;
      active_key <= '0;
      bcnt       <= '0;
    end else if (commit) begin
      shadow     <= merged;
      active_key <= merged;
      bcnt       <= '0;
    end else if (acc) begin
      shadow     <= merged;
      bcnt       <= bcnt + 1'b1;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = active_key[i % KEY_W];
  end

  // Unarmed data is forced to zero so nothing leaks through the gate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else if (key_armed && din_valid) begin
      dout_valid <= 1'b1;
      dout       <= din ^ mask;
    end else begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end
  end

endmodule

// File: tb/tb_xlock_key_loader.sv
// Directed bench for xlock_key_loader with default parameters.
module tb_xlock_key_loader;

  logic        clk = 1'b0;
  logic        rst_n, key_valid, key_ready, key_last, key_clear;
  logic [7:0]  key_data;
`ifdef XLOCK_KEY_PARITY_EN
  logic        key_par;
`endif
  logic        din_valid, dout_valid, key_armed, key_err;
  logic [31:0] din, dout;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  xlock_key_loader dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_data(key_data), .key_last(key_last),
`ifdef XLOCK_KEY_PARITY_EN
    .key_par(key_par),
`endif
    .key_clear(key_clear), .din_valid(din_valid), .din(din),
    .dout_valid(dout_valid), .dout(dout), .key_armed(key_armed), .key_err(key_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic wrong_par);
    key_valid = 1'b1;
    key_data  = d;
    key_last  = l;
`ifdef XLOCK_KEY_PARITY_EN
    key_par   = (^d) ^ wrong_par;
`else
    if (wrong_par) key_data = d;
`endif
    tick();
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_last = 1'b0; key_clear = 1'b0;
    key_data = '0; din_valid = 1'b0; din = '0;
`ifdef XLOCK_KEY_PARITY_EN
    key_par = 1'b0;
`endif
    repeat (3) tick();
    check("rst_ready", key_ready, 1);
    check("rst_armed", key_armed, 0);
    check("rst_err", key_err, 0);
    check("rst_dvalid", dout_valid, 0);
    check("rst_dout", dout, 0);
    rst_n = 1'b1;

    // Key A = 0x0807060504030201; data during the first load is dropped
    din_valid = 1'b1; din = 32'hFFFF_FFFF;
    for (int k = 0; k < 7; k++) send_beat(8'(k + 1), 1'b0, 1'b0);
    check("loadA_armed_pre", key_armed, 0);
    check("loadA_dvalid_pre", dout_valid, 0);
    send_beat(8'h08, 1'b1, 1'b0);
    check("loadA_armed", key_armed, 1);
    check("loadA_commit_drop", dout_valid, 0);
    tick();
    check("loadA_dvalid", dout_valid, 1);
    check("loadA_dout", dout, 32'hFBFC_FDFE);

    // Hot reload with key B = 0x1817161514131211; A stays in use through the commit edge
    for (int k = 0; k < 8; k++) begin
      send_beat(8'(8'h11 + k), k == 7, 1'b0);
      check("hot_dvalid", dout_valid, 1);
      check("hot_old_key", dout, 32'hFBFC_FDFE);
    end
    tick();
    check("hot_dvalid_after", dout_valid, 1);
    check("hot_new_key", dout, 32'hEBEC_EDEE);

    // Clear together with the fifth beat of a partial reload
    for (int k = 0; k < 4; k++) send_beat(8'hAA, 1'b0, 1'b0);
    key_clear = 1'b1;
    send_beat(8'hAA, 1'b0, 1'b0);
    key_clear = 1'b0;
    check("clr_armed", key_armed, 0);
    check("clr_err", key_err, 0);
    check("clr_ready", key_ready, 1);
    din = 32'h0000_0000;
    for (int k = 0; k < 8; k++) send_beat(8'(8'h21 + k), k == 7, 1'b0);
    check("clr_commit_armed", key_armed, 1);
    check("clr_commit_err", key_err, 0);
    tick();
    check("clr_fresh_mask", dout, 32'h2423_2221);

    // Early last on the third beat
    send_beat(8'h31, 1'b0, 1'b0);
    send_beat(8'h32, 1'b0, 1'b0);
    send_beat(8'h33, 1'b1, 1'b0);
    check("early_err", key_err, 1);
    check("early_ready", key_ready, 0);
    check("early_armed", key_armed, 0);
    din = 32'h1234_5678;
    tick();
    check("early_dvalid", dout_valid, 0);
    check("early_dout", dout, 0);
    send_beat(8'h01, 1'b1, 1'b0);
    check("err_sticky", key_err, 1);
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    check("err_clear", key_err, 0);
    check("err_clear_ready", key_ready, 1);

    // Missing last on the final beat
    for (int k = 0; k < 8; k++) send_beat(8'h5A, 1'b0, 1'b0);
    check("nolast_err", key_err, 1);
    key_clear = 1'b1; tick(); key_clear = 1'b0;

    // Reset mid-load discards the partial key
    for (int k = 0; k < 3; k++) send_beat(8'hC3, 1'b0, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) send_beat(8'(8'h41 + k), k == 7, 1'b0);
    check("rstmid_armed", key_armed, 1);
    din = 32'hFFFF_0000;
    tick();
    check("rstmid_mask", dout, 32'hBBBC_4241);

`ifdef XLOCK_KEY_PARITY_EN
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b0);
    send_beat(8'h03, 1'b0, 1'b1);
    check("par_err", key_err, 1);
    check("par_armed", key_armed, 0);
    key_clear = 1'b1; tick(); key_clear = 1'b0;
`endif

    din_valid = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
